// File: rtl/csa_mul8_seq_ctrl.sv
// csa_mul8_seq_ctrl: sequential 8x8 unsigned multiplier that reuses one 4x4
// carry-save array over four nibble partial products, accumulating into 16 bits.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b captured on accept)
//   a, b                8-bit unsigned operands
//   out_valid/out_ready result handshake
//   p                   16-bit product, valid while out_valid
//   busy                high outside IDLE
// csa_4_bit: combinational 4x4 unsigned carry-save array multiplier.
module csa_4_bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] prod
);
  logic [7:0] pp [4];
  logic [7:0] s1, c1, s2, c2, t0, t1, t2;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp[i] = 8'({4'b0, x & {4{y[i]}}} << i);
    end
    // two carry-save rows, then one carry-propagate add
    s1 = pp[0] ^ pp[1] ^ pp[2];
    c1 = (pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2]);
    t0 = s1;
    t1 = 8'(c1 << 1);
    t2 = pp[3];
    s2 = t0 ^ t1 ^ t2;
    c2 = (t0 & t1) | (t0 & t2) | (t1 & t2);
    prod = s2 + 8'(c2 << 1);
  end
endmodule

module csa_mul8_seq_ctrl #(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy
);
  localparam int unsigned OP_W  = 8;
  localparam int unsigned ACC_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP0  = 3'd1,
    PP1  = 3'd2,
    PP2  = 3'd3,
    PP3  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [OP_W-1:0]    a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [3:0]         nib_a, nib_b;
  logic [3:0]         shift;
  logic [7:0]         pp;

  // Is partial product k worth running for operands x/y?
  function automatic logic pp_required(input int unsigned k,
                                       input logic [7:0] x, input logic [7:0] y);
    logic [3:0] xn, yn;
    xn = k[0] ? x[7:4] : x[3:0];
    yn = k[1] ? y[7:4] : y[3:0];
    return !SKIP_ZERO || ((xn != 4'h0) && (yn != 4'h0));
  endfunction

  // First required PP state at or after index from, else DONE.
  function automatic state_t next_pp(input int unsigned from,
                                     input logic [7:0] x, input logic [7:0] y);
    state_t nxt;
    logic   found;
    nxt   = DONE;
    found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!found && k >= from && pp_required(k, x, y)) begin
        nxt   = state_t'(3'(k + 1));
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

  csa_4_bit u_csa (
    .x    (nib_a),
    .y    (nib_b),
    .prod (pp)
  );

  // Array operand steering; zeroed outside PP states.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    shift = 4'd0;
    unique case (state_q)
      PP0: begin nib_a = a_q[3:0]; nib_b = b_q[3:0]; shift = 4'd0; end
      PP1: begin nib_a = a_q[7:4]; nib_b = b_q[3:0]; shift = 4'd4; end
      PP2: begin nib_a = a_q[3:0]; nib_b = b_q[7:4]; shift = 4'd4; end
      PP3: begin nib_a = a_q[7:4]; nib_b = b_q[7:4]; shift = 4'd8; end
      default: ;
    endcase
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          state_d = next_pp(0, a, b);
        end
      end
      PP0, PP1, PP2, PP3: begin
        acc_d   = acc_q + (ACC_W'(pp) << shift);
        state_d = next_pp(32'(state_q), a_q, b_q);
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p         = acc_q;
endmodule

// File: tb/tb_csa_mul8_seq_ctrl.sv
module tb_csa_mul8_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv0 = 1'b0, iv1 = 1'b0;
  logic [7:0]  a = 8'h00, b = 8'h00;
  logic        out_ready = 1'b1;
  logic        ir0, ir1, ov0, ov1, bz0, bz1;
  logic [15:0] p0, p1;
  logic        sel = 1'b0;
  logic        s_ir, s_ov, s_bz;
  logic [15:0] s_p;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  csa_mul8_seq_ctrl #(.SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
    .out_valid(ov0), .out_ready(out_ready), .p(p0), .busy(bz0));

  csa_mul8_seq_ctrl #(.SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .out_valid(ov1), .out_ready(out_ready), .p(p1), .busy(bz1));

  assign s_ir = sel ? ir1 : ir0;
  assign s_ov = sel ? ov1 : ov0;
  assign s_bz = sel ? bz1 : bz0;
  assign s_p  = sel ? p1  : p0;

  typedef struct {
    logic        skip;
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] exp_p;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operand pair, measure latency and check the product/handshake.
  task automatic do_op(input logic skip, input logic [7:0] va, input logic [7:0] vb,
                       input logic [15:0] exp_p, input int exp_lat, input bit release_out);
    int cnt;
    sel = skip;
    cnt = 0;
    #1;
    while (!s_ir && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    check("ready_before_issue", 32'(s_ir), 32'd1);
    a = va; b = vb;
    if (skip) iv1 = 1'b1; else iv0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0; iv1 = 1'b0;
    a = 8'h5A; b = 8'hC3;  // changes after accept must be ignored
    check("in_ready_after_accept", 32'(s_ir), 32'd0);
    check("busy_after_accept", 32'(s_bz), 32'd1);
    cnt = 0;
    while (!s_ov && cnt < 10) begin
      @(posedge clk); #1; cnt++;
    end
    check("latency", 32'(cnt), 32'(exp_lat));
    check("product", 32'(s_p), 32'(exp_p));
    if (release_out) begin
      @(posedge clk); #1;
      check("out_valid_one_cycle", 32'(s_ov), 32'd0);
      check("in_ready_return", 32'(s_ir), 32'd1);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 4};
    vecs[1] = '{1'b0, 8'h12, 8'h34, 16'h03A8, 4};
    vecs[2] = '{1'b0, 8'h00, 8'h9C, 16'h0000, 4};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 16'h0023, 1};
    vecs[4] = '{1'b1, 8'h00, 8'hAB, 16'h0000, 0};
    vecs[5] = '{1'b1, 8'h50, 8'h03, 16'h00F0, 1};
    vecs[6] = '{1'b1, 8'hF0, 8'h0F, 16'h0E10, 1};
    vecs[7] = '{1'b1, 8'hFF, 8'hFF, 16'hFE01, 4};
    vecs[8] = '{1'b1, 8'h11, 8'h10, 16'h0110, 2};
    vecs[9] = '{1'b0, 8'h0B, 8'h0D, 16'h008F, 4};

    #12;
    check("rst_in_ready0", 32'(ir0), 32'd1);
    check("rst_out_valid0", 32'(ov0), 32'd0);
    check("rst_busy0", 32'(bz0), 32'd0);
    check("rst_p0", 32'(p0), 32'd0);
    check("rst_in_ready1", 32'(ir1), 32'd1);
    check("rst_p1", 32'(p1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].skip, vecs[i].va, vecs[i].vb, vecs[i].exp_p, vecs[i].exp_lat, 1'b1);
    end

    // Backpressure: result held while out_ready is low, new requests ignored.
    out_ready = 1'b0;
    do_op(1'b0, 8'hA5, 8'h3C, 16'h26AC, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      iv0 = (i % 2) == 0;
      a = 8'(8'h21 + i); b = 8'(8'h77 - i);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(ov0), 32'd1);
      check("bp_in_ready", 32'(ir0), 32'd0);
      check("bp_p_stable", 32'(p0), 32'h26AC);
    end
    iv0 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ov", 32'(ov0), 32'd0);
    check("bp_release_ir", 32'(ir0), 32'd1);
    check("bp_p_kept", 32'(p0), 32'h26AC);

    // Reset asserted while in PP2 takes effect without a clock edge.
    sel = 1'b0;
    a = 8'hFF; b = 8'hFF; iv0 = 1'b1;
    @(posedge clk); #1;  // accept -> PP0
    iv0 = 1'b0;
    @(posedge clk); #1;  // PP1
    @(posedge clk); #1;  // PP2
    check("pre_rst_busy", 32'(bz0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(ov0), 32'd0);
    check("midrst_p", 32'(p0), 32'd0);
    check("midrst_in_ready", 32'(ir0), 32'd1);
    check("midrst_busy", 32'(bz0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_out", 32'(ov0), 32'd0);
    do_op(1'b0, 8'h0B, 8'h0D, 16'h008F, 4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
